// File: rtl/regbank_wr_arbiter.sv
// Two-requester (ALU / load unit) writeback arbiter in front of the register bank.
// Round-robin on contention, one registered write per cycle, out-of-range and r0 writes are dropped.
module regbank_wr_arbiter #(
  parameter int NREG = 17,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [4:0]    a_dest,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [4:0]    b_dest,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          hold,
  output logic          wrReg,
  output logic [4:0]    destReg,
  output logic [DW-1:0] wrData,
  output logic          err,
  output logic [7:0]    drop_cnt
);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic dest_writable(input logic [4:0] d);
    return (d != 5'd0) && (int'(d) < NREG);
  endfunction

  function automatic logic dest_out_of_range(input logic [4:0] d);
    return int'(d) >= NREG;
  endfunction

  // last_b_p1 = 1 means B was granted most recently, so A wins the next contention.
  logic          last_b_p1;
  logic          gnt_a_p0;
  logic          gnt_b_p0;
  logic          vld_p0;
  logic [4:0]    dest_p0;
  logic [DW-1:0] data_p0;
  logic          wr_ok_p0;
  logic          drop_p0;
  logic          oor_p0;

  logic          vld_p1;
  logic [4:0]    dest_p1;
  logic [DW-1:0] data_p1;
  logic          err_p1;
  logic [7:0]    drop_cnt_p1;

  // Stage p0: arbitration and classification of the accepted request.
  always_comb begin
    gnt_a_p0 = a_valid && (!b_valid || last_b_p1);
    gnt_b_p0 = b_valid && (!a_valid || !last_b_p1);
  end

  assign a_ready = gnt_a_p0 && !hold && !rst;
  assign b_ready = gnt_b_p0 && !hold && !rst;

  always_comb begin
    vld_p0   = a_ready || b_ready;
    dest_p0  = b_ready ? b_dest : a_dest;
    data_p0  = b_ready ? b_data : a_data;
    wr_ok_p0 = vld_p0 && dest_writable(dest_p0);
    drop_p0  = vld_p0 && !dest_writable(dest_p0);
    oor_p0   = vld_p0 && dest_out_of_range(dest_p0);
  end

  // Stage p1: registered write port, sticky error and drop statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      dest_p1     <= '0;
      data_p1     <= '0;
      err_p1      <= 1'b0;
      drop_cnt_p1 <= '0;
      last_b_p1   <= 1'b1;
    end else begin
      vld_p1 <= wr_ok_p0;
      if (wr_ok_p0) begin
        dest_p1 <= dest_p0;
        data_p1 <= data_p0;
      end
      if (vld_p0) last_b_p1 <= b_ready;
      if (drop_p0) drop_cnt_p1 <= sat_inc(drop_cnt_p1);
      if (oor_p0) err_p1 <= 1'b1;
    end
  end

  assign wrReg    = vld_p1;
  assign destReg  = dest_p1;
  assign wrData   = data_p1;
  assign err      = err_p1;
  assign drop_cnt = drop_cnt_p1;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Scoreboard bench for regbank_wr_arbiter: a cycle model predicts grants, writes, err and drop_cnt.
module tb_regbank_wr_arbiter;
  localparam int NREG = 17;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, hold;
  logic [4:0]    a_dest, b_dest;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          wrReg, err;
  logic [4:0]    destReg;
  logic [DW-1:0] wrData;
  logic [7:0]    drop_cnt;

  regbank_wr_arbiter #(.NREG(NREG), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready),
    .hold(hold),
    .wrReg(wrReg), .destReg(destReg), .wrData(wrData),
    .err(err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [4:0]    dest;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  int            total = 0;
  int            bad = 0;
  logic          m_last_b;
  logic [4:0]    m_dest;
  logic [DW-1:0] m_data;
  logic          m_err;
  logic [7:0]    m_drop;
  string         grant_log;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last_b = 1'b1;
    m_dest   = '0;
    m_data   = '0;
    m_err    = 1'b0;
    m_drop   = '0;
    sb_q.delete();
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".wrReg"}, 64'(wrReg), 64'(1'b0));
    check({tag, ".destReg"}, 64'(destReg), 64'(m_dest));
    check({tag, ".wrData"}, 64'(wrData), 64'(m_data));
    check({tag, ".err"}, 64'(err), 64'(m_err));
    check({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_valid = 1'b1; a_dest = 5'd2; a_data = 32'hDEAD;
    b_valid = 1'b1; b_dest = 5'd3; b_data = 32'hBEEF;
    hold = 1'b0;
    model_reset();
    #1;
    check("rst.a_ready", 64'(a_ready), 64'(1'b0));
    check("rst.b_ready", 64'(b_ready), 64'(1'b0));
    @(posedge clk);
    #1;
    check_regs("rst");
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b0;
  endtask

  // One bus cycle: drive at negedge, check ready and push the expected write,
  // then pop and compare after the next rising edge.
  task automatic step(input logic av, input logic [4:0] ad, input logic [DW-1:0] adt,
                      input logic bv, input logic [4:0] bd, input logic [DW-1:0] bdt,
                      input logic h);
    logic          ga, gb;
    logic [4:0]    d;
    logic [DW-1:0] dt;
    exp_t          e;
    @(negedge clk);
    a_valid = av; a_dest = ad; a_data = adt;
    b_valid = bv; b_dest = bd; b_data = bdt;
    hold = h;
    #1;
    ga = av && (!bv || m_last_b) && !h;
    gb = bv && (!av || !m_last_b) && !h;
    check("a_ready", 64'(a_ready), 64'(ga));
    check("b_ready", 64'(b_ready), 64'(gb));
    e.wr = 1'b0;
    if (ga || gb) begin
      d  = ga ? ad : bd;
      dt = ga ? adt : bdt;
      m_last_b = gb;
      grant_log = {grant_log, ga ? "A" : "B"};
      if (d != 5'd0 && int'(d) < NREG) begin
        e.wr = 1'b1;
        m_dest = d;
        m_data = dt;
      end else begin
        if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
        if (int'(d) >= NREG) m_err = 1'b1;
      end
    end
    e.dest = m_dest;
    e.data = m_data;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard.empty", 64'(1), 64'(0));
    end else begin
      e = sb_q.pop_front();
      check("wrReg", 64'(wrReg), 64'(e.wr));
      check("destReg", 64'(destReg), 64'(e.dest));
      check("wrData", 64'(wrData), 64'(e.data));
      check("err", 64'(err), 64'(m_err));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    end
  endtask

  task automatic idle();
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_dest = '0; a_data = '0;
    b_valid = 1'b0; b_dest = '0; b_data = '0;
    hold = 1'b0;
    grant_log = "";
    model_reset();

    do_reset();

    // Single ALU write, latency one.
    step(1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, '0, 1'b0);
    check("first.destReg", 64'(destReg), 64'(5'd3));
    check("first.wrData", 64'(wrData), 64'(32'h1234));
    idle();

    // Contention from reset: A,B,A,B with back-to-back writes.
    do_reset();
    grant_log = "";
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd5, 32'hA000 + i, 1'b1, 5'd6, 32'hB000 + i, 1'b0);
      check("rr.wrReg", 64'(wrReg), 64'(1'b1));
      check("rr.destReg", 64'(destReg), (i % 2 == 0) ? 64'd5 : 64'd6);
    end
    check("rr.order", 64'(grant_log == "ABAB"), 64'(1));
    idle();

    // Same destination from both: the later write lands on the next cycle.
    step(1'b1, 5'd7, 32'h1111, 1'b1, 5'd7, 32'h2222, 1'b0);
    step(1'b1, 5'd7, 32'h1111, 1'b1, 5'd7, 32'h2222, 1'b0);
    idle();

    // Drop to r0: accepted, counted, no error.
    do_reset();
    step(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h55, 1'b0);
    check("r0.drop_cnt", 64'(drop_cnt), 64'd1);
    check("r0.err", 64'(err), 64'd0);

    // Out-of-range destination sets the sticky error.
    do_reset();
    step(1'b1, 5'd20, 32'h77, 1'b0, 5'd0, '0, 1'b0);
    check("oor.err", 64'(err), 64'd1);
    check("oor.drop_cnt", 64'(drop_cnt), 64'd1);
    step(1'b1, 5'd16, 32'h99, 1'b0, 5'd0, '0, 1'b0);
    idle();
    check("oor.sticky", 64'(err), 64'd1);

    // Hold right after an accepted write, then hold with contention.
    do_reset();
    step(1'b1, 5'd9, 32'hCAFE, 1'b0, 5'd0, '0, 1'b0);
    step(1'b1, 5'd9, 32'hCAFE, 1'b1, 5'd10, 32'hF00D, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 5'd11, 32'h1, 1'b1, 5'd12, 32'h2, 1'b1);
    grant_log = "";
    step(1'b1, 5'd11, 32'h1, 1'b1, 5'd12, 32'h2, 1'b0);
    check("hold.first_grant", 64'(grant_log == "A"), 64'(1));
    idle();

    // Randomised mix, including hold and out-of-range indices.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 20)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 20)), $urandom,
           1'($urandom_range(0, 4) == 0));

    // Saturation of the drop counter.
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 5'd0, 32'(i), 1'b0, 5'd0, '0, 1'b0);
    check("sat.drop_cnt", 64'(drop_cnt), 64'd255);

    // Asynchronous reset while a write is on the outputs.
    step(1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, '0, 1'b0);
    check("async.pre_wrReg", 64'(wrReg), 64'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check("async.wrReg", 64'(wrReg), 64'd0);
    check("async.destReg", 64'(destReg), 64'd0);
    check("async.wrData", 64'(wrData), 64'd0);
    check("async.drop_cnt", 64'(drop_cnt), 64'd0);
    check("async.a_ready", 64'(a_ready), 64'd0);
    do_reset();
    step(1'b1, 5'd1, 32'h0101, 1'b0, 5'd0, '0, 1'b0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/regbank_wr_arbiter.md
REGBANK_WR_ARBITER -- requirements
Module: regbank_wr_arbiter

Interface
REQ-001 SHALL have parameter NREG, default 17, number of writable register indices (0..NREG-1; index 16 = RET).
REQ-002 SHALL have parameter DW, default 32, write data width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 a_valid  input  1  ALU writeback request.
REQ-006 a_dest  input  5  ALU destination register index.
REQ-007 a_data  input  DW  ALU writeback data.
REQ-008 a_ready  output  1  ALU request accepted this cycle.
REQ-009 b_valid  input  1  load-unit writeback request.
REQ-010 b_dest  input  5  load destination register index.
REQ-011 b_data  input  DW  load writeback data.
REQ-012 b_ready  output  1  load request accepted this cycle.
REQ-013 hold  input  1  freeze grants; no requests are accepted while high.
REQ-014 wrReg  output  1  registered write enable to register bank.
REQ-015 destReg  output  5  registered write index.
REQ-016 wrData  output  DW  registered write data.
REQ-017 err  output  1  sticky: an out-of-range destination was seen.
REQ-018 drop_cnt  output  8  saturating count of dropped (accepted, not written) requests.

Function
REQ-019 A request SHALL transfer when valid and ready are both high at a rising clk edge; at most one transfer per cycle in total.
REQ-020 x_ready SHALL be combinational: low when hold=1; otherwise high only for the requester granted this cycle.
REQ-021 Grant: only one valid -> that requester; both valid -> the requester not granted most recently (round-robin pointer).
REQ-022 Round-robin pointer SHALL update only on a transfer, to the requester just granted; it holds when idle or under hold.
REQ-023 A requester holding valid without ready SHALL keep dest/data stable; the arbiter need not check this.
REQ-024 Accepted request with dest in 1..NREG-1 SHALL drive wrReg=1, destReg=dest, wrData=data on the cycle after acceptance (latency 1).
REQ-025 Accepted request with dest=0 SHALL be dropped: wrReg=0 next cycle; drop_cnt increments; err unaffected.
REQ-026 Accepted request with dest>=NREG SHALL be dropped: wrReg=0 next cycle; drop_cnt increments; err set to 1.
REQ-027 drop_cnt SHALL saturate at 255 and never wrap.
REQ-028 Any cycle without a writable transfer SHALL drive wrReg=0; destReg/wrData hold previous values.
REQ-029 Both valid, same dest: loser's write SHALL follow the winner's, one cycle later; the last write wins in the register bank.
REQ-030 hold rising mid-stream SHALL not cancel the write already registered; that write still appears on the next edge.
REQ-031 err SHALL clear only on rst.

Reset
REQ-032 On rst high, asynchronously: wrReg=0, destReg=0, wrData=0, err=0, drop_cnt=0, round-robin pointer = B-last, so A wins the first contention.
REQ-033 While rst is high, a_ready=b_ready=0; an in-flight registered write is discarded.
REQ-034 First grant SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-035 Reset release, then a_valid=1 a_dest=3 a_data=0x1234 for one cycle -> a_ready=1; next cycle wrReg=1 destReg=3 wrData=0x1234.
REQ-036 a and b both valid for 4 cycles (dests 5, 6) -> grants A,B,A,B; wrReg high 4 consecutive cycles with destReg 5,6,5,6.
REQ-037 b_valid with b_dest=0 -> b_ready=1, wrReg stays 0, drop_cnt 0->1, err=0.
REQ-038 a_valid with a_dest=20 -> accepted, wrReg=0, err=1 and stays 1; drop_cnt=1.
REQ-039 hold=1 with both valid for 3 cycles -> both ready low, wrReg=0; hold=0 -> A granted first (pointer unchanged).
REQ-040 300 dest=0 drops -> drop_cnt=255; rst asserted mid-write -> wrReg=0 immediately, counters cleared.
